led_frame_sequencer: RTL and testbench
======================================

# led_frame_sequencer

Frame-rate controller for the serial LED driver chain. A free-running frame timer starts one frame per period. For each frame, the block fetches every channel word from an external pixel memory and shifts it out MSB first on `o_clk`/`o_dai`. It then pulses `o_lat` to transfer the shifted data to the driver outputs. The block sits between the pixel/animation store and the LED driver pins, and replaces ad-hoc counter logic at the top level.

## Interface
Parameters:
- `FRAME_PERIOD`, 16666: `i_clk` cycles per frame tick.
- `FRAME_MAX`, 120: frame counter wraps to 0 after `FRAME_MAX-1`.
- `NUM_CHANNELS`, 48: channel words per frame.
- `BITS`, 16: bits per channel word.
- `CLK_DIV`, 2: `i_clk` cycles per `o_clk` half-period (≥1).

Ports:
- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  when high, frame ticks start frames; when low, ticks are ignored.
- `o_rd_addr`  out  $clog2(NUM_CHANNELS)  pixel memory address.
- `i_rd_data`  in  BITS  pixel word, valid exactly 1 cycle after `o_rd_addr`.
- `o_clk`  out  1  serial shift clock.
- `o_dai`  out  1  serial data.
- `o_lat`  out  1  latch pulse.
- `o_busy`  out  1  high while a frame transfer is in progress.
- `o_frame_done`  out  1  one-cycle pulse at the end of the latch.
- `o_frame_count`  out  $clog2(FRAME_MAX)  completed-frame index.
- `o_overrun_count`  out  8  skipped-tick count; see Configuration.

## Operation
- **Reset values:** all outputs are 0, the FSM is in IDLE, and the timer is 0.
- **Frame timer:** counts 0..`FRAME_PERIOD-1` and wraps. A tick is asserted when the count equals `FRAME_PERIOD-1`. The timer runs regardless of `i_enable`.
- **FSM states:** IDLE, LOAD, FETCH, SHIFT, LATCH.
- **IDLE:**
  - tick && `i_enable` → LOAD; the channel index is set to `NUM_CHANNELS-1`.
- **LOAD:**
  - drive `o_rd_addr` = channel index.
  - → FETCH.
- **FETCH:**
  - capture `i_rd_data` into the shift register.
  - → SHIFT, with the bit index set to `BITS-1`.
- **SHIFT:**
  - each bit occupies `2*CLK_DIV` cycles: `o_clk` is low for the first `CLK_DIV` cycles, high for the next `CLK_DIV`.
  - `o_dai` is the current MSB and is stable for the whole bit.
  - after bit 0:
    - if channel index > 0: decrement the index, → LOAD.
    - if channel index = 0: → LATCH.
- **Channel order:** channels are sent from highest address down to address 0 (daisy-chain order, last driver first).
- **LATCH:**
  - `o_clk` = 0, `o_lat` = 1 for `2*CLK_DIV` cycles.
  - then → IDLE, with `o_frame_done` pulsed for 1 cycle.
  - `o_frame_count` increments at that pulse, wrapping `FRAME_MAX-1` → 0.
- **`o_busy`:** 1 in every state except IDLE.
- **`o_clk` outside SHIFT:** 0 in LOAD, FETCH, LATCH and IDLE.
- **`o_dai` outside SHIFT:** 0 in IDLE and LATCH.
- **Overrun:** a tick arriving while not in IDLE does not restart or queue a frame; it is dropped.
- **`i_enable` deasserted mid-frame:** the current frame completes normally.
- **`i_rst` mid-frame:** on the next edge, the FSM returns to IDLE and all outputs go to 0. No latch is issued, and the partial data in the chain is discarded.
- **Simultaneous events:** a tick and `o_frame_done` can occur in the same cycle. The FSM is still in LATCH on that cycle, so the tick counts as an overrun.

## Timing
- Tick to `o_busy` high: 1 cycle. Tick to first valid `o_rd_addr`: 1 cycle.
- Cycles per channel: 2 + `BITS*2*CLK_DIV`. With defaults: 66.
- Frame duration: `NUM_CHANNELS*(2+BITS*2*CLK_DIV) + 2*CLK_DIV` cycles. With defaults: 3172, well below `FRAME_PERIOD`.
- Serial data is sampled by the driver on the rising edge of `o_clk`. `o_dai` changes only while `o_clk` is low, or on the same cycle `o_clk` falls.
- All arithmetic is unsigned, at the minimum widths from `$clog2`. Counter compares are width-matched against truncated parameter constants.

## Configuration
- Macro: `LED_SEQ_OVERRUN_CNT_EN`.
- **Defined:** `o_overrun_count` increments on each dropped tick (busy && tick, regardless of `i_enable`). It saturates at 255 and clears only on `i_rst`.
- **Undefined:** no counter logic is generated, and `o_overrun_count` is tied to 0.

## Structure
- The shared package `lamp_pkg` holds:
  - the FSM state typedef (`led_seq_state_t`);
  - default localparams for frame period, frame max and channel count, also used by the top level.
- Sub-module `led_frame_timer`: a free-running period counter with a one-cycle tick output, parameterised by `FRAME_PERIOD`. The FSM, shift register and counters live in `led_frame_sequencer`.

## Test plan
All scenarios use `FRAME_PERIOD`=200, `NUM_CHANNELS`=2, `BITS`=4, `CLK_DIV`=1 unless noted.
- **Basic frame:** memory[1]=4'hA, memory[0]=4'h5, enable high.
  - First tick at cycle 199 → `o_dai` bits 1,0,1,0,0,1,0,1 sampled on `o_clk` rising edges.
  - `o_lat` high for 2 cycles, then `o_frame_done` pulse; `o_frame_count`=1.
  - Frame length 2*(2+8)+2 = 22 cycles.
- **Enable low:** `i_enable`=0 across 3 ticks → no `o_clk` edges, `o_busy`=0, `o_frame_count`=0.
- **Frame count wrap:** `FRAME_MAX`=3, run 4 frames → `o_frame_count` sequence 1,2,0,1.
- **Overrun (macro defined):** `FRAME_PERIOD`=15, which is shorter than the 22-cycle frame.
  - `o_overrun_count` increments once per dropped tick.
  - Frames still complete intact, with one latch per completed frame.
- **Reset mid-shift:** assert `i_rst` for 1 cycle during the channel 0 SHIFT.
  - Next cycle: `o_clk`=`o_dai`=`o_lat`=`o_busy`=0 and `o_frame_count`=0.
  - No `o_lat` pulse follows.
- **Macro undefined:** rerun the overrun scenario → `o_overrun_count` stays 0.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared FSM state type and default sizing for the LED frame sequencer.
// Default parameter values here are also the top-level defaults.
package lamp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_LATCH = 3'd4
    } led_seq_state_t;

    localparam int LED_FRAME_PERIOD = 16666;
    localparam int LED_FRAME_MAX    = 120;
    localparam int LED_NUM_CHANNELS = 48;
    localparam int LED_BITS         = 16;
    localparam int LED_CLK_DIV      = 2;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int value);
        return (value > 32'sd1) ? $clog2(value) : 32'sd1;
    endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Pixel-memory read port between the frame sequencer (master) and the
// pixel/animation store (slave); read data follows the address by one cycle.
interface led_frame_sequencer_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic [AW-1:0] o_rd_addr;
    logic [DW-1:0] i_rd_data;

    modport master (output o_rd_addr, input  i_rd_data);
    modport slave  (input  o_rd_addr, output i_rd_data);
endinterface

// File: rtl/led_frame_timer.sv
// Free-running frame period counter; o_tick is high for the single cycle
// in which the count equals FRAME_PERIOD-1.
module led_frame_timer
    import lamp_pkg::*;
#(
    parameter int FRAME_PERIOD = LED_FRAME_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int            TW   = clog2_min1(FRAME_PERIOD);
    localparam logic [TW-1:0] LAST = TW'(FRAME_PERIOD - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;
    logic          tick_q;

    // Next count, wrapping after the last cycle of the period.
    always_comb begin
        count_d = count_q;
        if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + TW'(1);
        end
    end

    // Tick is registered from the next count so it lines up with count == LAST.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= (count_d == LAST);
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame-rate controller: fetches every channel word per frame tick, shifts it
// out MSB first on o_clk/o_dai, then latches. Optional: LED_SEQ_OVERRUN_CNT_EN.
module led_frame_sequencer
    import lamp_pkg::*;
#(
    parameter int FRAME_PERIOD = LED_FRAME_PERIOD,
    parameter int FRAME_MAX    = LED_FRAME_MAX,
    parameter int NUM_CHANNELS = LED_NUM_CHANNELS,
    parameter int BITS         = LED_BITS,
    parameter int CLK_DIV      = LED_CLK_DIV
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_enable,
    led_frame_sequencer_if.master                pix,
    output logic                                 o_clk,
    output logic                                 o_dai,
    output logic                                 o_lat,
    output logic                                 o_busy,
    output logic                                 o_frame_done,
    output logic [clog2_min1(FRAME_MAX)-1:0]     o_frame_count,
    output logic [7:0]                           o_overrun_count
);
    localparam int AW = clog2_min1(NUM_CHANNELS);
    localparam int BW = clog2_min1(BITS);
    localparam int PW = clog2_min1(2 * CLK_DIV);
    localparam int FW = clog2_min1(FRAME_MAX);

    localparam logic [AW-1:0] CH_LAST  = AW'(NUM_CHANNELS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV);
    localparam logic [FW-1:0] FC_LAST  = FW'(FRAME_MAX - 1);

    led_seq_state_t  state_q, state_d;
    logic [AW-1:0]   chan_q, chan_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [FW-1:0]   fcount_q, fcount_d;
    logic            clk_q, clk_d;
    logic            dai_q, dai_d;
    logic            lat_q, lat_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick_s;

    led_frame_timer #(
        .FRAME_PERIOD(FRAME_PERIOD)
    ) u_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .o_tick(tick_s)
    );

    // Sequencing: ph_q counts cycles within a bit and within the latch pulse.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_s && i_enable) begin
                    state_d = ST_LOAD;
                    chan_d  = CH_LAST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                shift_d = pix.i_rd_data;
                bit_d   = BIT_LAST;
                ph_d    = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ph_q != PH_LAST) begin
                    ph_d = ph_q + PW'(1);
                end else begin
                    ph_d = '0;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BW'(1);
                        shift_d = shift_q << 1;
                    end else if (chan_q != '0) begin
                        chan_d  = chan_q - AW'(1);
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (ph_q != PH_LAST) begin
                    ph_d = ph_q + PW'(1);
                end else begin
                    ph_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so pins change with the state.
    always_comb begin
        addr_d   = (state_d == ST_LOAD) ? chan_d : addr_q;
        clk_d    = (state_d == ST_SHIFT) && (ph_d >= PH_HALF);
        dai_d    = (state_d == ST_SHIFT) && shift_d[BITS-1];
        lat_d    = (state_d == ST_LATCH);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_LATCH) && (ph_d == PH_LAST);
        fcount_d = fcount_q;
        if (done_d) begin
            if (fcount_q == FC_LAST) begin
                fcount_d = '0;
            end else begin
                fcount_d = fcount_q + FW'(1);
            end
        end else begin
            fcount_d = fcount_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            chan_q   <= '0;
            bit_q    <= '0;
            ph_q     <= '0;
            shift_q  <= '0;
            addr_q   <= '0;
            fcount_q <= '0;
            clk_q    <= 1'b0;
            dai_q    <= 1'b0;
            lat_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            bit_q    <= bit_d;
            ph_q     <= ph_d;
            shift_q  <= shift_d;
            addr_q   <= addr_d;
            fcount_q <= fcount_d;
            clk_q    <= clk_d;
            dai_q    <= dai_d;
            lat_q    <= lat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef LED_SEQ_OVERRUN_CNT_EN
    logic [7:0] ovr_q;

    // Saturating count of ticks dropped because a frame was still in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovr_q <= 8'd0;
        end else if (tick_s && busy_q && (ovr_q != 8'hFF)) begin
            ovr_q <= ovr_q + 8'd1;
        end else begin
            ovr_q <= ovr_q;
        end
    end

    assign o_overrun_count = ovr_q;
`else
    assign o_overrun_count = 8'd0;
`endif

    assign pix.o_rd_addr = addr_q;
    assign o_clk         = clk_q;
    assign o_dai         = dai_q;
    assign o_lat         = lat_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;
    assign o_frame_count = fcount_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: three parameterisations (basic/wrap, overrun,
// wider CLK_DIV) checked against a frame-level model of the bit stream.
module tb_led_frame_sequencer;
    localparam int CH_N[3]  = '{2, 2, 3};
    localparam int BIT_N[3] = '{4, 4, 5};
    localparam int DIV_N[3] = '{1, 1, 2};
    localparam int FP_N[3]  = '{200, 15, 100};

    logic       clk;
    logic       rst_s [3];
    logic       en_s  [3];
    logic       oclk_p [3];
    logic       dai_p  [3];
    logic       lat_p  [3];
    logic       busy_p [3];
    logic       done_p [3];
    logic [7:0] ovr_p  [3];
    logic [7:0] fc_p   [3];
    logic [7:0] addr_p [3];
    logic [1:0] fc_a;
    logic [6:0] fc_b, fc_c;
    logic [15:0] mem [3][4];

    int tests_run    = 0;
    int tests_failed = 0;

    led_frame_sequencer_if #(.AW(1), .DW(4)) bus_a ();
    led_frame_sequencer_if #(.AW(1), .DW(4)) bus_b ();
    led_frame_sequencer_if #(.AW(2), .DW(5)) bus_c ();

    led_frame_sequencer #(.FRAME_PERIOD(200), .FRAME_MAX(3), .NUM_CHANNELS(2), .BITS(4), .CLK_DIV(1)) dut_a (
        .i_clk(clk), .i_rst(rst_s[0]), .i_enable(en_s[0]), .pix(bus_a.master),
        .o_clk(oclk_p[0]), .o_dai(dai_p[0]), .o_lat(lat_p[0]), .o_busy(busy_p[0]),
        .o_frame_done(done_p[0]), .o_frame_count(fc_a), .o_overrun_count(ovr_p[0]));

    led_frame_sequencer #(.FRAME_PERIOD(15), .FRAME_MAX(120), .NUM_CHANNELS(2), .BITS(4), .CLK_DIV(1)) dut_b (
        .i_clk(clk), .i_rst(rst_s[1]), .i_enable(en_s[1]), .pix(bus_b.master),
        .o_clk(oclk_p[1]), .o_dai(dai_p[1]), .o_lat(lat_p[1]), .o_busy(busy_p[1]),
        .o_frame_done(done_p[1]), .o_frame_count(fc_b), .o_overrun_count(ovr_p[1]));

    led_frame_sequencer #(.FRAME_PERIOD(100), .FRAME_MAX(120), .NUM_CHANNELS(3), .BITS(5), .CLK_DIV(2)) dut_c (
        .i_clk(clk), .i_rst(rst_s[2]), .i_enable(en_s[2]), .pix(bus_c.master),
        .o_clk(oclk_p[2]), .o_dai(dai_p[2]), .o_lat(lat_p[2]), .o_busy(busy_p[2]),
        .o_frame_done(done_p[2]), .o_frame_count(fc_c), .o_overrun_count(ovr_p[2]));

    assign fc_p[0]   = {6'd0, fc_a};
    assign fc_p[1]   = {1'b0, fc_b};
    assign fc_p[2]   = {1'b0, fc_c};
    assign addr_p[0] = {7'd0, bus_a.o_rd_addr};
    assign addr_p[1] = {7'd0, bus_b.o_rd_addr};
    assign addr_p[2] = {6'd0, bus_c.o_rd_addr};

    // Pixel memories with one cycle of read latency.
    always @(posedge clk) begin
        bus_a.i_rd_data <= mem[0][bus_a.o_rd_addr][3:0];
        bus_b.i_rd_data <= mem[1][bus_b.o_rd_addr][3:0];
        bus_c.i_rd_data <= mem[2][bus_c.o_rd_addr][4:0];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected serial stream: highest channel first, each word MSB first.
    function automatic logic [63:0] exp_bits(input int k);
        logic [63:0] e;
        e = '0;
        for (int ch = CH_N[k] - 1; ch >= 0; ch--) begin
            for (int b = BIT_N[k] - 1; b >= 0; b--) begin
                e = {e[62:0], mem[k][ch][b]};
            end
        end
        return e;
    endfunction

    function automatic int frame_len(input int k);
        return CH_N[k] * (2 + BIT_N[k] * 2 * DIV_N[k]) + 2 * DIV_N[k];
    endfunction

    // Tick every P cycles; a tick starts a frame only if no frame is busy.
    function automatic void model_overrun(input int kcyc, input int p, input int len,
                                          output int ovr, output int frames);
        int busy_last;
        busy_last = -1;
        ovr = 0;
        frames = 0;
        for (int c = 0; c < kcyc; c++) begin
            if (c % p == p - 1) begin
                if (c <= busy_last) begin
                    ovr++;
                end else begin
                    busy_last = c + len;
                    if (c + len <= kcyc) frames++;
                end
            end
        end
        if (ovr > 255) ovr = 255;
    endfunction

    task automatic randomize_mem(input int k);
        for (int ch = 0; ch < 4; ch++) begin
            mem[k][ch] = 16'($urandom_range(0, (1 << BIT_N[k]) - 1));
        end
    endtask

    task automatic capture(input int k, input int budget, input int drop_after,
                           output logic [63:0] bits, output int nbits, output int lat_cyc,
                           output int busy_cyc, output int glitch, output int first_busy,
                           output logic [7:0] first_addr, output bit got_done);
        logic pclk, pdai;
        pclk = 1'b0; pdai = 1'b0; bits = '0; nbits = 0; lat_cyc = 0; busy_cyc = 0;
        glitch = 0; first_busy = -1; first_addr = 8'd0; got_done = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (busy_p[k]) begin
                if (first_busy < 0) begin
                    first_busy = i;
                    first_addr = addr_p[k];
                end
                busy_cyc++;
                if (drop_after > 0 && busy_cyc == drop_after) en_s[k] = 1'b0;
            end
            if (lat_p[k]) begin
                lat_cyc++;
                if (oclk_p[k]) glitch++;
            end
            if (oclk_p[k] && !pclk) begin
                bits = {bits[62:0], dai_p[k]};
                nbits++;
            end
            if (oclk_p[k] && pclk && (dai_p[k] !== pdai)) glitch++;
            pclk = oclk_p[k];
            pdai = dai_p[k];
            if (done_p[k]) begin
                got_done = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input int k, input string name, input int budget,
                               input int drop_after, input logic [7:0] exp_fc);
        logic [63:0] bits;
        logic [7:0] faddr;
        int nbits, lat_cyc, busy_cyc, glitch, first_busy;
        bit got_done;
        logic [63:0] e;
        e = exp_bits(k);
        capture(k, budget, drop_after, bits, nbits, lat_cyc, busy_cyc, glitch, first_busy, faddr, got_done);
        tests_run++;
        if (got_done !== 1'b1 || nbits != CH_N[k] * BIT_N[k] || bits !== e) begin
            tests_failed++;
            $display("FAIL %s stream: done=%0d nbits=%0d got=%h required=%h", name, got_done, nbits, bits, e);
        end
        tests_run++;
        if (lat_cyc != 2 * DIV_N[k] || busy_cyc != frame_len(k) || glitch != 0) begin
            tests_failed++;
            $display("FAIL %s timing: lat=%0d busy=%0d glitch=%0d required lat=%0d busy=%0d glitch=0",
                     name, lat_cyc, busy_cyc, glitch, 2 * DIV_N[k], frame_len(k));
        end
        tests_run++;
        if (fc_p[k] !== exp_fc) begin
            tests_failed++;
            $display("FAIL %s frame_count: got=%0d required=%0d", name, fc_p[k], exp_fc);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1;
            en_s[k]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({oclk_p[k], dai_p[k], lat_p[k], busy_p[k], done_p[k]} !== 5'b0 ||
                fc_p[k] !== 8'd0 || ovr_p[k] !== 8'd0 || addr_p[k] !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset_state[%0d]: pins=%b fc=%0d ovr=%0d addr=%0d required all 0",
                         k, {oclk_p[k], dai_p[k], lat_p[k], busy_p[k], done_p[k]}, fc_p[k], ovr_p[k], addr_p[k]);
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [63:0] bits;
        logic [7:0] faddr;
        int nbits, lat_cyc, busy_cyc, glitch, first_busy;
        bit got_done;
        mem[0][1] = 16'hA;
        mem[0][0] = 16'h5;
        en_s[0] = 1'b1;
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        capture(0, 260, 0, bits, nbits, lat_cyc, busy_cyc, glitch, first_busy, faddr, got_done);
        tests_run++;
        if (first_busy != 200 || faddr !== 8'd1) begin
            tests_failed++;
            $display("FAIL basic_start: busy_cycle=%0d addr=%0d required 200 and 1", first_busy, faddr);
        end
        tests_run++;
        if (got_done !== 1'b1 || nbits != 8 || bits !== 64'hA5) begin
            tests_failed++;
            $display("FAIL basic_stream: done=%0d nbits=%0d got=%h required=a5", got_done, nbits, bits);
        end
        tests_run++;
        if (lat_cyc != 2 || busy_cyc != 22 || glitch != 0) begin
            tests_failed++;
            $display("FAIL basic_timing: lat=%0d busy=%0d glitch=%0d required 2 22 0", lat_cyc, busy_cyc, glitch);
        end
        tests_run++;
        if (fc_p[0] !== 8'd1) begin
            tests_failed++;
            $display("FAIL basic_count: got=%0d required=1", fc_p[0]);
        end
    endtask

    task automatic test_frame_wrap();
        int frames;
        frames = 1;
        for (int f = 0; f < 3; f++) begin
            randomize_mem(0);
            frames++;
            check_frame(0, "wrap_frame", 260, 0, 8'(frames % 3));
        end
    endtask

    task automatic test_enable_low();
        int clk_hi, busy_hi;
        clk_hi = 0;
        busy_hi = 0;
        en_s[2] = 1'b0;
        for (int i = 0; i < 350; i++) begin
            @(negedge clk);
            if (oclk_p[2]) clk_hi++;
            if (busy_p[2] || lat_p[2]) busy_hi++;
        end
        tests_run++;
        if (clk_hi != 0 || busy_hi != 0 || fc_p[2] !== 8'd0) begin
            tests_failed++;
            $display("FAIL enable_low: clk_hi=%0d busy=%0d fc=%0d required 0 0 0", clk_hi, busy_hi, fc_p[2]);
        end
    endtask

    task automatic test_random_frames();
        int busy_hi;
        en_s[2] = 1'b1;
        for (int f = 0; f < 4; f++) begin
            randomize_mem(2);
            check_frame(2, "div2_frame", 200, (f == 3) ? 30 : 0, 8'(f + 1));
        end
        busy_hi = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (busy_p[2]) busy_hi++;
        end
        tests_run++;
        if (busy_hi != 0 || fc_p[2] !== 8'd4) begin
            tests_failed++;
            $display("FAIL enable_drop_idle: busy=%0d fc=%0d required 0 4", busy_hi, fc_p[2]);
        end
    endtask

    task automatic test_overrun();
        logic [63:0] cur, e;
        logic pclk, plat;
        int ncur, dones, latches, bad, exp_ovr, exp_frames;
        randomize_mem(1);
        e = exp_bits(1);
        @(negedge clk);
        rst_s[1] = 1'b1;
        @(negedge clk);
        rst_s[1] = 1'b0;
        en_s[1] = 1'b1;
        cur = '0; ncur = 0; dones = 0; latches = 0; bad = 0; pclk = 1'b0; plat = 1'b0;
        for (int i = 1; i <= 8000; i++) begin
            @(negedge clk);
            if (oclk_p[1] && !pclk) begin
                cur = {cur[62:0], dai_p[1]};
                ncur++;
            end
            if (lat_p[1] && !plat) latches++;
            pclk = oclk_p[1];
            plat = lat_p[1];
            if (done_p[1]) begin
                dones++;
                if (ncur != 8 || cur !== e) bad++;
                cur = '0;
                ncur = 0;
            end
            if (i == 310) begin
                model_overrun(i, FP_N[1], frame_len(1), exp_ovr, exp_frames);
`ifndef LED_SEQ_OVERRUN_CNT_EN
                exp_ovr = 0;
`endif
                tests_run++;
                if (ovr_p[1] !== 8'(exp_ovr) || dones != exp_frames) begin
                    tests_failed++;
                    $display("FAIL overrun_early: ovr=%0d frames=%0d required %0d %0d", ovr_p[1], dones, exp_ovr, exp_frames);
                end
            end
        end
        model_overrun(8000, FP_N[1], frame_len(1), exp_ovr, exp_frames);
`ifndef LED_SEQ_OVERRUN_CNT_EN
        exp_ovr = 0;
`endif
        tests_run++;
        if (ovr_p[1] !== 8'(exp_ovr)) begin
            tests_failed++;
            $display("FAIL overrun_saturate: got=%0d required=%0d", ovr_p[1], exp_ovr);
        end
        tests_run++;
        if (dones != exp_frames || latches != dones || bad != 0) begin
            tests_failed++;
            $display("FAIL overrun_frames: frames=%0d latches=%0d bad=%0d required %0d %0d 0",
                     dones, latches, bad, exp_frames, exp_frames);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit found;
        int lats;
        found = 1'b0;
        en_s[0] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy_p[0] && oclk_p[0] && addr_p[0] == 8'd0) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL midshift_wait: channel 0 shift not seen, required within 400 cycles");
        end
        rst_s[0] = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({oclk_p[0], dai_p[0], lat_p[0], busy_p[0]} !== 4'b0 || fc_p[0] !== 8'd0) begin
            tests_failed++;
            $display("FAIL midshift_reset: clk/dai/lat/busy=%b fc=%0d required 0000 0",
                     {oclk_p[0], dai_p[0], lat_p[0], busy_p[0]}, fc_p[0]);
        end
        rst_s[0] = 1'b0;
        lats = 0;
        for (int i = 0; i < 190; i++) begin
            @(negedge clk);
            if (lat_p[0] || busy_p[0]) lats++;
        end
        tests_run++;
        if (lats != 0) begin
            tests_failed++;
            $display("FAIL midshift_no_latch: lat/busy cycles=%0d required 0", lats);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < 4; ch++) mem[k][ch] = 16'd0;
        end
        test_reset();
        test_basic_frame();
        test_frame_wrap();
        test_enable_low();
        test_random_frames();
        test_overrun();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
